// File: rtl/bus_xcvr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_xcvr_arbiter_if
//  Brief    : Requester / transceiver-bank signal bundle for bus_xcvr_arbiter.
//             The slave side is the arbiter. The master side is the
//             requesters plus the 74245 bank.
//  Revision : 1.0  initial release
// ============================================================================
interface bus_xcvr_arbiter_if #(
  parameter int N = 4
) ();
  logic [N-1:0] req;   // requester i wants the bus
  logic [N-1:0] drv;   // requester i drives (A->B) when 1, reads (B->A) when 0
  logic [N-1:0] gnt;   // one-hot: bus owned by i and settled
  logic [N-1:0] nOE;   // active-low transceiver output enables
  logic [N-1:0] DIR;   // transceiver directions, 1 = A->B
  logic         busy;  // arbiter is not idle

  modport slave (
    input  req,
    input  drv,
    output gnt,
    output nOE,
    output DIR,
    output busy
  );

  modport master (
    output req,
    output drv,
    input  gnt,
    input  nOE,
    input  DIR,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/bus_xcvr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_xcvr_arbiter
//  Brief    : Round-robin owner of a shared tri-state bus reached through one
//             74245 per requester. It sequences DIR, then nOE, then gnt, so
//             that at most one transceiver is enabled at a time. DIR only
//             moves while the transceiver is disabled, and a dead-time gap
//             follows every release.
//  Revision : 1.0  initial release
// ============================================================================
module bus_xcvr_arbiter #(
  parameter int N             = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int DEAD_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  bus_xcvr_arbiter_if.slave bus
);

  localparam int c_OW = (N > 1) ? $clog2(N) : 1;
  // Wide enough for any cycle-count parameter up to 255.
  localparam int c_CW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  state_t            r_state,  w_state;
  logic [c_OW-1:0]   r_owner,  w_owner;
  logic [c_OW-1:0]   r_rr_ptr, w_rr_ptr;
  logic [c_CW-1:0]   r_cnt,    w_cnt;
  logic [N-1:0]      r_noe,    w_noe;
  logic [N-1:0]      r_dir,    w_dir;
  logic [N-1:0]      r_gnt,    w_gnt;
  logic              w_pick_valid;
  logic [c_OW-1:0]   w_pick;

  // Modulo-N wrap for an index that can be at most 2N-2.
  function automatic logic [c_OW-1:0] f_wrap(input int v);
    int t;
    t = (v >= N) ? v - N : v;
    return c_OW'(t);
  endfunction

  // Round-robin search. The loop runs from the farthest offset down to
  // offset 0, so the set request nearest to rr_ptr is the last one written
  // and wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = r_rr_ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_pick_valid = 1'b1;
        w_pick       = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // pins change only on clock edges.
  always_comb begin
    w_state  = r_state;
    w_owner  = r_owner;
    w_rr_ptr = r_rr_ptr;
    w_cnt    = r_cnt;
    w_noe    = r_noe;
    w_dir    = r_dir;
    w_gnt    = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          // Direction is latched here, while the transceiver is still off.
          w_owner        = w_pick;
          w_dir[w_pick]  = bus.drv[w_pick];
          w_cnt          = c_CW'(SETUP_CYCLES - 1);
          w_state        = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!bus.req[r_owner]) begin
          w_noe[r_owner] = 1'b1;
          w_cnt          = c_CW'(DEAD_CYCLES - 1);
          w_state        = ST_DEAD;
        end else if (r_cnt == '0) begin
          w_noe[r_owner] = 1'b0;
          w_cnt          = c_CW'(SETTLE_CYCLES - 1);
          w_state        = ST_SETTLE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!bus.req[r_owner]) begin
          // An abort still pays the dead time. gnt was never raised.
          w_noe[r_owner] = 1'b1;
          w_cnt          = c_CW'(DEAD_CYCLES - 1);
          w_state        = ST_DEAD;
        end else if (r_cnt == '0) begin
          w_gnt[r_owner] = 1'b1;
          w_state        = ST_ACTIVE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      ST_ACTIVE: begin
        // drv is ignored here. A direction change needs a fresh request.
        if (!bus.req[r_owner]) begin
          w_gnt          = '0;
          w_noe[r_owner] = 1'b1;
          w_cnt          = c_CW'(DEAD_CYCLES - 1);
          w_state        = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (r_cnt == '0) begin
          w_rr_ptr = f_wrap(int'(r_owner) + 1);
          w_state  = ST_IDLE;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_noe   = '1;
        w_gnt   = '0;
      end
    endcase
  end

  // State register. Reset releases the bus at the same edge it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_noe    <= '1;
      r_dir    <= '1;
      r_gnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_owner  <= w_owner;
      r_rr_ptr <= w_rr_ptr;
      r_cnt    <= w_cnt;
      r_noe    <= w_noe;
      r_dir    <= w_dir;
      r_gnt    <= w_gnt;
    end
  end

  assign bus.nOE  = r_noe;
  assign bus.DIR  = r_dir;
  assign bus.gnt  = r_gnt;
  assign bus.busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
